// File: rtl/dot_product_initiator_pkg.sv
// rtl/dot_product_initiator_pkg.sv - shared types and field helpers for the dot-product initiator
package dot_product_initiator_pkg;

    // Group phase: accumulating products, or holding a finished sum
    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    // Width of a counter that must reach k inclusive
    function automatic int count_width(input int k);
        return (k < 1) ? 1 : $clog2(k + 1);
    endfunction

    // Operand-pair message layout, shared with the multiplier harness:
    // operand a occupies the upper word, operand b the lower word.
    function automatic int msg_a_msb(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int msg_a_lsb(input int n);
        return n;
    endfunction

    function automatic int msg_b_msb(input int n);
        return n - 1;
    endfunction

    function automatic int msg_b_lsb(input int n);
        return (n > 0) ? 0 : 0;
    endfunction

endpackage

// File: rtl/dot_product_initiator.sv
// rtl/dot_product_initiator.sv - issues operand pairs to a multiplier and sums every k products
module dot_product_initiator
    import dot_product_initiator_pkg::*;
#(
    parameter int n = 32,
    parameter int d = 16,
    parameter int k = 4
) (
    input  logic           clk,
    input  logic           reset,

    input  logic           in_val,
    output logic           in_rdy,
    input  logic [2*n-1:0] in_msg,

    output logic           mul_send_val,
    input  logic           mul_send_rdy,
    output logic [2*n-1:0] mul_send_msg,

    input  logic           mul_recv_val,
    output logic           mul_recv_rdy,
    input  logic [n-1:0]   mul_recv_msg,

    output logic           out_val,
    input  logic           out_rdy,
    output logic [n-1:0]   out_msg
);

    localparam int            CW      = count_width(k);
    localparam logic [CW-1:0] K_CNT   = CW'(k);
    localparam logic [CW-1:0] K_LAST  = CW'(k - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Reject parameter sets the datapath cannot represent
    if (k < 1 || d < 0 || d >= n) begin : g_bad_params
        $error("dot_product_initiator: requires k >= 1 and 0 <= d < n");
    end

    state_t        state;
    state_t        state_next;
    logic [n-1:0]  acc;
    logic [CW-1:0] issued;
    logic [CW-1:0] received;

    logic          can_issue;
    logic          req_fire;
    logic          resp_fire;
    logic          last_product;

    // The request path is a pure pass-through; only the handshake is gated
    assign mul_send_msg = in_msg;
    assign out_msg      = acc;

    // Next-state and handshake decode; every handshake is held low during reset
    always_comb begin
        state_next   = state;
        in_rdy       = 1'b0;
        mul_send_val = 1'b0;
        mul_recv_rdy = 1'b0;
        out_val      = 1'b0;
        req_fire     = 1'b0;
        resp_fire    = 1'b0;
        last_product = 1'b0;
        can_issue    = (issued < K_CNT);
        if (!reset) begin
            case (state)
                ACC: begin
                    in_rdy       = mul_send_rdy && can_issue;
                    mul_send_val = in_val && can_issue;
                    mul_recv_rdy = 1'b1;
                    req_fire     = in_val && mul_send_rdy && can_issue;
                    resp_fire    = mul_recv_val;
                    last_product = mul_recv_val && (received == K_LAST);
                    if (last_product) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    out_val = 1'b1;
                    if (out_rdy) begin
                        state_next = ACC;
                    end
                end
                default: begin
                    state_next = ACC;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    // Request and response counters; cleared when the sum is handed off
    always_ff @(posedge clk) begin
        if (reset) begin
            issued   <= '0;
            received <= '0;
        end else if (state == DONE) begin
            if (out_rdy) begin
                issued   <= '0;
                received <= '0;
            end
        end else begin
            if (req_fire) begin
                issued <= issued + CNT_ONE;
            end
            if (resp_fire) begin
                received <= received + CNT_ONE;
            end
        end
    end

    // Accumulator: wraps modulo 2^n, cleared when the sum is handed off
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (state == DONE) begin
            if (out_rdy) begin
                acc <= '0;
            end
        end else if (resp_fire) begin
            acc <= acc + mul_recv_msg;
        end
    end

endmodule

// File: tb/tb_dot_product_initiator.sv
// tb/tb_dot_product_initiator.sv - directed self-checking bench for dot_product_initiator
module tb_dot_product_initiator;

    logic        clk;
    logic        reset;

    logic        in_val, in_rdy;
    logic [63:0] in_msg;
    logic        mul_send_val, mul_send_rdy;
    logic [63:0] mul_send_msg;
    logic        mul_recv_val, mul_recv_rdy;
    logic [31:0] mul_recv_msg;
    logic        out_val, out_rdy;
    logic [31:0] out_msg;

    logic        in_val1, in_rdy1;
    logic [63:0] in_msg1;
    logic        send_val1, send_rdy1;
    logic [63:0] send_msg1;
    logic        recv_val1, recv_rdy1;
    logic [31:0] recv_msg1;
    logic        out_val1, out_rdy1;
    logic [31:0] out_msg1;

    int passed = 0;
    int total  = 0;

    int send_pct  = 100;
    int max_delay = 0;
    int hold_len  = 0;

    logic [31:0] mq[$];
    logic [31:0] got[$];
    bit          presenting = 0;
    int          wait_cnt   = 0;
    int          max_out    = 0;
    int          stable_err = 0;
    int          done_err   = 0;
    int          done_cyc   = 0;
    bit          have_prev  = 0;
    logic [31:0] prev_msg;

    dot_product_initiator #(.n(32), .d(16), .k(4)) u_dut (
        .clk(clk), .reset(reset),
        .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .mul_send_val(mul_send_val), .mul_send_rdy(mul_send_rdy), .mul_send_msg(mul_send_msg),
        .mul_recv_val(mul_recv_val), .mul_recv_rdy(mul_recv_rdy), .mul_recv_msg(mul_recv_msg),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg)
    );

    dot_product_initiator #(.n(32), .d(16), .k(1)) u_dut_k1 (
        .clk(clk), .reset(reset),
        .in_val(in_val1), .in_rdy(in_rdy1), .in_msg(in_msg1),
        .mul_send_val(send_val1), .mul_send_rdy(send_rdy1), .mul_send_msg(send_msg1),
        .mul_recv_val(recv_val1), .mul_recv_rdy(recv_rdy1), .mul_recv_msg(recv_msg1),
        .out_val(out_val1), .out_rdy(out_rdy1), .out_msg(out_msg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[47:16];
    endfunction

    // Multiplier model: captures requests, retires presented products
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            presenting = 0;
            wait_cnt   = 0;
        end else begin
            if (mul_recv_val && mul_recv_rdy) begin
                void'(mq.pop_front());
                presenting = 0;
                wait_cnt   = $urandom_range(0, max_delay);
            end
            if (mul_send_val && mul_send_rdy) begin
                if (mq.size() == 0 && !presenting) wait_cnt = $urandom_range(0, max_delay);
                mq.push_back(qmul(mul_send_msg[63:32], mul_send_msg[31:0]));
            end
            if (mq.size() > max_out) max_out = mq.size();
        end
    end

    // Multiplier model: presents the head product after a random delay
    always @(negedge clk) begin
        if (presenting) begin
            mul_recv_val = 1'b1;
        end else if (mq.size() > 0 && wait_cnt == 0) begin
            mul_recv_val = 1'b1;
            mul_recv_msg = mq[0];
            presenting   = 1;
        end else begin
            mul_recv_val = 1'b0;
            if (mq.size() > 0 && wait_cnt > 0) wait_cnt--;
        end
    end

    // Output sink: holds out_rdy low for hold_len cycles, watches DONE behaviour
    always @(negedge clk) begin
        if (reset) begin
            done_cyc  = 0;
            out_rdy   = 1'b0;
            have_prev = 0;
        end else if (out_val) begin
            if (have_prev && out_msg !== prev_msg) stable_err++;
            if (in_rdy || mul_send_val || mul_recv_rdy) done_err++;
            prev_msg  = out_msg;
            have_prev = 1;
            done_cyc++;
            if (done_cyc > hold_len) begin
                out_rdy = 1'b1;
                got.push_back(out_msg);
            end else begin
                out_rdy = 1'b0;
            end
        end else begin
            done_cyc  = 0;
            out_rdy   = 1'b0;
            have_prev = 0;
        end
    end

    task automatic feed(input logic [31:0] a, input logic [31:0] b);
        int tries;
        bit done;
        tries = 0;
        done  = 0;
        @(negedge clk);
        in_val = 1'b1;
        in_msg = {a, b};
        while (!done) begin
            mul_send_rdy = ($urandom_range(0, 99) < send_pct);
            #1;
            if (in_rdy) begin
                done = 1;
            end else if (tries >= 500) begin
                check("feed_timeout", 64'd0, 64'd1);
                done = 1;
            end else begin
                @(negedge clk);
                tries++;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_val       = 1'b0;
        mul_send_rdy = 1'b1;
    endtask

    task automatic wait_outputs(input int count);
        int t;
        t = 0;
        while (got.size() < count && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("outputs_seen", 64'(got.size()), 64'(count));
    endtask

    task automatic basic_group();
        feed(32'h0001_0000, 32'h0002_0000);
        feed(32'h0000_8000, 32'h0004_0000);
        feed(32'hFFFF_0000, 32'h0001_0000);
        feed(32'h0003_0000, 32'h0000_4000);
    endtask

    task automatic k1_product(input logic [31:0] p);
        @(negedge clk);
        in_val1 = 1'b1;
        in_msg1 = {32'h0001_0000, p};
        #1;
        check("k1_in_rdy", 64'(in_rdy1), 64'd1);
        check("k1_send_msg", send_msg1, {32'h0001_0000, p});
        @(negedge clk);
        in_val1 = 1'b0;
        #1;
        check("k1_in_rdy_full", 64'(in_rdy1), 64'd0);
        recv_val1 = 1'b1;
        recv_msg1 = p;
        @(negedge clk);
        recv_val1 = 1'b0;
        #1;
        check("k1_out_val", 64'(out_val1), 64'd1);
        check("k1_out_msg", 64'(out_msg1), 64'(p));
        check("k1_recv_rdy_done", 64'(recv_rdy1), 64'd0);
        out_rdy1 = 1'b1;
        @(negedge clk);
        out_rdy1 = 1'b0;
        #1;
        check("k1_cleared", {31'd0, out_val1, out_msg1}, 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        in_val = 1'b1;
        in_msg = {32'h0001_0000, 32'h0001_0000};
        mul_send_rdy = 1'b1;
        mul_recv_val = 1'b0;
        mul_recv_msg = '0;
        in_val1 = 1'b1;
        in_msg1 = '0;
        send_rdy1 = 1'b1;
        recv_val1 = 1'b1;
        recv_msg1 = '0;
        out_rdy1 = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_in_rdy", 64'(in_rdy), 64'd0);
        check("rst_send_val", 64'(mul_send_val), 64'd0);
        check("rst_recv_rdy", 64'(mul_recv_rdy), 64'd0);
        check("rst_out_val", 64'(out_val), 64'd0);

        @(negedge clk);
        reset = 1'b0;
        in_val = 1'b0;
        in_val1 = 1'b0;
        recv_val1 = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_out", {31'd0, out_val, out_msg}, 64'd0);

        // Combinational pass-through with the multiplier stalled
        mul_send_rdy = 1'b0;
        in_val = 1'b1;
        in_msg = {32'h1234_5678, 32'h9ABC_DEF0};
        #1;
        check("pass_msg", mul_send_msg, 64'h1234_5678_9ABC_DEF0);
        check("pass_val", 64'(mul_send_val), 64'd1);
        check("stall_in_rdy", 64'(in_rdy), 64'd0);
        in_val = 1'b0;
        mul_send_rdy = 1'b1;

        // Basic Q16.16 group: 2 + 2 - 1 + 0.75
        basic_group();
        idle_in();
        wait_outputs(1);
        check("basic_sum", 64'(got[0]), 64'h0003_C000);
        repeat (4) @(negedge clk);
        check("basic_single", 64'(got.size()), 64'd1);
        check("basic_clear", {31'd0, out_val, out_msg}, 64'd0);

        // Back-to-back groups of 1.0 * 1.0
        for (int i = 0; i < 12; i++) feed(32'h0001_0000, 32'h0001_0000);
        idle_in();
        wait_outputs(4);
        check("b2b_0", 64'(got[1]), 64'h0004_0000);
        check("b2b_1", 64'(got[2]), 64'h0004_0000);
        check("b2b_2", 64'(got[3]), 64'h0004_0000);
        repeat (3) @(negedge clk);
        check("b2b_clear", {31'd0, out_val, out_msg}, 64'd0);

        // Backpressure on every port, then a wrapping group queued behind it
        send_pct  = 50;
        max_delay = 5;
        hold_len  = 10;
        basic_group();
        for (int i = 0; i < 4; i++) feed(32'h7FFF_0000, 32'h0001_0000);
        idle_in();
        wait_outputs(6);
        check("bp_sum", 64'(got[4]), 64'h0003_C000);
        check("wrap_sum", 64'(got[5]), 64'hFFFC_0000);
        check("bp_stable", 64'(stable_err), 64'd0);
        check("bp_done_gating", 64'(done_err), 64'd0);
        check("max_outstanding", 64'(max_out <= 4), 64'd1);
        send_pct  = 100;
        max_delay = 0;
        hold_len  = 0;
        repeat (3) @(negedge clk);

        // Reset after two of four products of a group
        feed(32'h0001_0000, 32'h0001_0000);
        feed(32'h0001_0000, 32'h0001_0000);
        idle_in();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("partial_no_out", 64'(got.size()), 64'd6);
        check("partial_out_val", 64'(out_val), 64'd0);
        basic_group();
        idle_in();
        wait_outputs(7);
        check("fresh_sum", 64'(got[6]), 64'h0003_C000);

        // k = 1: each product is echoed as its own sum
        k1_product(32'h0001_2345);
        k1_product(32'hFFFE_8000);
        k1_product(32'h7FFF_FFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dot_product_initiator.md
# dot_product_initiator

Initiator for the fixed-point multiplier harness's val/rdy request/response interface. It accepts a stream of operand pairs, issues each pair to the multiplier as a packed request, and collects the product responses. It sums every `k` consecutive products and emits each sum as one fixed-point result. It sits between an operand producer and the multiplier harness, and forms the core of a dot-product/FIR stage.

## Interface
Parameters:
- `n`, 32: word width of operands, products and sum.
- `d`, 16: fractional bits. The same Q format is used on all ports. No rescaling happens here.
- `k`, 4: products summed per output. Must be ≥ 1.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `in_val`, in, 1: upstream operand pair valid.
- `in_rdy`, out, 1: this block accepts the upstream pair.
- `in_msg`, in, 2n: operand pair. `a` = `[2n-1:n]`, `b` = `[n-1:0]`.
- `mul_send_val`, out, 1: request to multiplier valid.
- `mul_send_rdy`, in, 1: multiplier accepts the request.
- `mul_send_msg`, out, 2n: packed request. `a` in the upper half, `b` in the lower half.
- `mul_recv_val`, in, 1: product valid.
- `mul_recv_rdy`, out, 1: this block accepts the product.
- `mul_recv_msg`, in, n: product `a*b` in Q(n-d).d.
- `out_val`, out, 1: sum valid.
- `out_rdy`, in, 1: downstream accepts the sum.
- `out_msg`, out, n: accumulated sum.

## Operation
- States: `ACC` (issue requests and accumulate products) and `DONE` (hold the sum until it is taken).
- Registers:
  - `acc[n-1:0]`.
  - `issued` and `received`, each `$clog2(k+1)` bits.
  - `state`.
- Request path in `ACC` is combinational pass-through:
  - `mul_send_msg = in_msg`.
  - `mul_send_val = in_val && issued<k`.
  - `in_rdy = mul_send_rdy && issued<k`.
  - On the fire (`in_val && in_rdy`), `issued` increments.
- Response path in `ACC`:
  - `mul_recv_rdy = 1`.
  - On the fire, `acc <= acc + mul_recv_msg` (two's complement, wraps mod 2^n, no saturation) and `received` increments.
- When the fire delivers the k-th product (`received == k-1`):
  - `acc` takes the final sum.
  - Next state is `DONE`.
- `DONE`:
  - `out_val = 1`, `out_msg = acc`.
  - `in_rdy = 0`, `mul_send_val = 0`, `mul_recv_rdy = 0`.
  - On `out_rdy`: `acc`, `issued` and `received` clear to 0, and the next state is `ACC`.
- Request fire and response fire in the same cycle are both legal and both take effect.
- At most `k` requests are ever outstanding, so all requests of a group belong to that group. No products are dropped or double-counted across groups.
- Backpressure: stalls on any port hold all state. `mul_send_msg` always equals `in_msg` combinationally.

## Timing
- While `reset` is high, `in_rdy`, `mul_send_val`, `mul_recv_rdy` and `out_val` are forced to 0.
- The cycle after `reset` deasserts: `state = ACC`, `acc = 0`, `issued = 0`, `received = 0`, `out_val = 0`, `out_msg = 0`.
- Request latency: 0 cycles from `in_val` to `mul_send_val` (combinational).
- Output latency: `out_val` rises the cycle after the k-th product handshake. The minimum group period is k+1 cycles plus multiplier latency.
- Reset asserted mid-group discards `acc` and the counts. Products for requests already in flight belong to the multiplier's own reset domain, and the multiplier must be reset together with this block.
- `k = 1`: each product goes straight to `DONE` with `out_msg` equal to that product.

## Structure
- Shared package holds:
  - the state enum (`ACC`, `DONE`);
  - a count-width helper (`$clog2(k+1)`);
  - the pack/unpack field positions for the `2n` operand message, shared with the multiplier harness.
- Single flat module, about 150 lines. No sub-module is needed.
- The verification top pairs this block with the multiplier harness, with `n`, `d` and `k` matched.

## Test plan
- Basic group, `k=4`, Q16.16. Pairs (0x00010000,0x00020000), (0x00008000,0x00040000), (0xFFFF0000,0x00010000), (0x00030000,0x00004000). Required: exactly one `out_msg = 0x0003C000` (3.75).
- Reset: `out_val`, `in_rdy`, `mul_send_val` and `mul_recv_rdy` are 0 during reset. The first output after reset equals a fresh group sum with no stale `acc`.
- Backpressure:
  - `mul_send_rdy` random 50%, `mul_recv_val` delayed 0–5 cycles, `out_rdy` held low 10 cycles.
  - Required: `in_rdy = 0` in `DONE`, the sum is held stable, and never more than `k` requests are outstanding.
- Back-to-back groups: 3 groups of all-(1.0,1.0) pairs give 3 outputs of 0x00040000, each followed by a clean clear.
- Wrap-around: 4 products of 0x7FFF0000 give `out_msg` = 0xFFFC0000 (mod 2^32, no saturation).
- `k=1` and mid-group reset:
  - With `k=1`, every product is echoed on `out_msg`.
  - A reset after 2 of 4 products leaves no output from the partial group.
